// File: rtl/wb_single_master.sv
// Wishbone pipelined-mode initiator: one valid/ready command becomes one Wishbone
// read or write, with stall, error and lost-acknowledge timeout handling.
module wb_single_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic        we_q;
  logic [29:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        ready_q;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_tmo_q, rsp_tmo_d;
  logic        accept;
  logic        term;
  logic        expire;

  // Byte offset bits never reach the bus.
  logic unused_adr_bits;
  assign unused_adr_bits = ^cmd_adr_i[1:0];

  assign accept = (state_q == IDLE) && cmd_valid_i;
  assign expire = (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    rsp_tmo_d = rsp_tmo_q;
    term      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = REQ;
          tmo_d   = '0;
        end
      end
      REQ, WAIT: begin
        // A termination while still stalled in REQ is not a response to our strobe.
        term = (wb_ack_i || wb_err_i) && ((state_q == WAIT) || !wb_stall_i);
        if (term) begin
          state_d   = RESP;
          rsp_err_d = wb_err_i;
          rsp_tmo_d = 1'b0;
          rsp_dat_d = (wb_err_i || we_q) ? 32'd0 : wb_dat_i;
        end else if (expire) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
          rsp_tmo_d = 1'b1;
          rsp_dat_d = 32'd0;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if ((state_q == REQ) && !wb_stall_i) begin
            state_d = WAIT;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      ready_q   <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      ready_q   <= (state_d == IDLE);
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      rsp_tmo_q <= rsp_tmo_d;
      if (accept) begin
        we_q  <= cmd_we_i;
        adr_q <= cmd_adr_i[31:2];
        dat_q <= cmd_dat_i;
        sel_q <= cmd_sel_i;
      end
    end
  end

  assign cmd_ready_o   = ready_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_tmo_q;
  assign wb_cyc_o      = (state_q == REQ) || (state_q == WAIT);
  assign wb_stb_o      = (state_q == REQ);
  assign wb_we_o       = we_q;
  assign wb_adr_o      = {adr_q, 2'b00};
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;

endmodule

// File: tb/tb_wb_single_master.sv
// Bench for wb_single_master: behavioural memory responder plus a response scoreboard.
module tb_wb_single_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_to;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        ack, err, stall;
  logic        r_ack, r_err, stray;
  logic [31:0] r_dat;

  always #5 clk = ~clk;

  wb_single_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_to),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
    .wb_dat_o(wdat), .wb_sel_o(sel), .wb_dat_i(rdat),
    .wb_ack_i(ack), .wb_err_i(err), .wb_stall_i(stall)
  );

  // Responder: registered, ack delayed by ack_dly cycles; mode 0 ack, 1 err, 2 silent.
  int          mode = 0;
  int          ack_dly = 0;
  logic [31:0] mem [0:255];
  logic        pend;
  int          dly;
  logic [31:0] p_adr, p_dat;
  logic [3:0]  p_sel;
  logic        p_we;

  assign ack  = r_ack | stray;
  assign err  = r_err;
  assign rdat = r_dat;

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s);
    logic [31:0] m;
    if (mode == 1) begin
      r_err <= 1'b1;
    end else begin
      r_ack <= 1'b1;
      m = mem[a[9:2]];
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
        mem[a[9:2]] <= m;
      end
      r_dat <= m;
    end
  endtask

  always @(posedge clk) begin
    r_ack <= 1'b0;
    r_err <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else if (pend) begin
      if (dly == 0) begin
        pend <= 1'b0;
        issue(p_adr, p_we, p_dat, p_sel);
      end else begin
        dly <= dly - 1;
      end
    end else if (cyc && stb && !stall && mode != 2) begin
      if (ack_dly == 0) begin
        issue(adr, we, wdat, sel);
      end else begin
        pend <= 1'b1; dly <= ack_dly - 1;
        p_adr <= adr; p_we <= we; p_dat <= wdat; p_sel <= sel;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        to;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Monitor on the falling edge.
  int          cyc_n = 0;
  int          acc_cyc = 0;
  int          run = 0, stb_run = 0, last_run = 0, last_stb = 0;
  logic [31:0] last_adr = 0, prev_adr = 0, prev_dat = 0;
  logic        prev_valid = 0, prev_ready = 0, prev_stb = 0;
  logic        prev_err = 0, prev_to = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run = 0; stb_run = 0; prev_valid = 0; prev_stb = 0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc_n;
      if (cyc) begin
        run++;
        if (stb) begin
          stb_run++;
          last_adr = adr;
          if (prev_stb) check("stb_adr_stable", adr, prev_adr);
        end
      end else if (run > 0) begin
        last_run = run; last_stb = stb_run; run = 0; stb_run = 0;
      end
      if (rsp_valid) check("ready_low_in_resp", {31'd0, cmd_ready}, 32'd0);
      if (rsp_valid && prev_valid && !prev_ready) begin
        check("rsp_dat_stable", rsp_dat, prev_dat);
        check("rsp_flags_stable", {30'd0, rsp_err, rsp_to}, {30'd0, prev_err, prev_to});
      end
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else if (sb[0].lat >= 0) check("rsp_latency", cyc_n - acc_cyc, sb[0].lat);
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_dat", rsp_dat, e.dat);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_timeout", {31'd0, rsp_to}, {31'd0, e.to});
      end
      prev_valid = rsp_valid; prev_ready = rsp_ready; prev_dat = rsp_dat;
      prev_err = rsp_err; prev_to = rsp_to; prev_stb = stb; prev_adr = adr;
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic push, input logic [31:0] edat,
                      input logic eerr, input logic eto, input int elat);
    int n = 0;
    exp_t e;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 32'd0, 32'd1);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
    if (push) begin
      e.dat = edat; e.err = eerr; e.to = eto; e.lat = elat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_dat = 32'hFFFF_FFFF;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() > 0) begin
      check("rsp_wait", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
    rsp_ready = 1'b1; stall = 1'b0; stray = 1'b0;
    r_ack = 0; r_err = 0; r_dat = 0; pend = 0; dly = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_wb_ctl", {29'd0, cyc, stb, we}, 32'd0);
    check("rst_wb_adr", adr, 32'd0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_err | rsp_to}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Write then read, back to back.
    send(1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'd0, 0, 0, 3);
    send(0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEEF, 0, 0, 3);
    wait_rsp();

    // Byte-lane write with an unaligned command address.
    send(1, 32'h20, 32'h11223344, 4'hF, 1, 32'd0, 0, 0, 3);
    send(1, 32'h23, 32'h0000AA00, 4'b0010, 1, 32'd0, 0, 0, 3);
    wait_rsp();
    check("adr_aligned", last_adr, 32'h20);
    send(0, 32'h20, 32'h0, 4'hF, 1, 32'h1122AA44, 0, 0, 3);
    wait_rsp();

    // Five stall cycles.
    stall = 1'b1;
    send(0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEEF, 0, 0, 8);
    repeat (5) @(posedge clk);
    #1 stall = 1'b0;
    wait_rsp();
    check("stall_stb_cycles", last_stb, 32'd6);

    // Error alone.
    mode = 1;
    send(0, 32'h10, 32'h0, 4'hF, 1, 32'd0, 1, 0, 3);
    wait_rsp();

    // Silent responder: timeout after 8 cyc cycles.
    mode = 2;
    send(0, 32'h10, 32'h0, 4'hF, 1, 32'd0, 1, 1, 9);
    wait_rsp();
    check("timeout_cyc_cycles", last_run, 32'd8);

    // Ack in the last permitted cycle wins over the timeout.
    mode = 0; ack_dly = 6;
    send(0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEEF, 0, 0, 9);
    wait_rsp();
    check("late_ack_cyc_cycles", last_run, 32'd8);
    ack_dly = 0;

    // Response backpressure with a stray ack during RESP, then a stray ack in IDLE.
    rsp_ready = 1'b0;
    send(0, 32'h20, 32'h0, 4'hF, 1, 32'h1122AA44, 0, 0, 3);
    repeat (4) @(posedge clk);
    #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    wait_rsp();
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    check("idle_stray_ready", {31'd0, cmd_ready}, 32'd1);
    check("idle_stray_bus", {30'd0, cyc, rsp_valid}, 32'd0);

    // Reset while waiting for an ack.
    mode = 2;
    send(0, 32'h10, 32'h0, 4'hF, 0, 32'd0, 0, 0, -1);
    @(posedge clk); #1;
    check("in_wait", {30'd0, cyc, stb}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_bus", {30'd0, cyc, stb}, 32'd0);
    check("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    mode = 0;
    @(posedge clk); #1;
    check("rst_rel_rsp", {31'd0, rsp_valid}, 32'd0);
    send(0, 32'h20, 32'h0, 4'hF, 1, 32'h1122AA44, 0, 0, 3);
    wait_rsp();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
